// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/done request bus (i_start, i_op, i_op1, i_op2 in; o_busy, o_done, o_result out) with master/slave modports
interface muldiv_if #(parameter int DATA_WIDTH = 32);
  logic                  i_start;
  logic [1:0]            i_op;
  logic [DATA_WIDTH-1:0] i_op1;
  logic [DATA_WIDTH-1:0] i_op2;
  logic                  o_busy;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_result;
  modport master (output i_start, i_op, i_op1, i_op2, input o_busy, o_done, o_result);
  modport slave (input i_start, i_op, i_op1, i_op2, output o_busy, o_done, o_result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned MUL/MULHU/DIVU/REMU, one bit per cycle; ports i_clk, i_rst_n (sync active-low), io_bus (muldiv_if slave)
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input logic      i_clk,
  input logic      i_rst_n,
  muldiv_if.slave  io_bus
);
  localparam int W = DATA_WIDTH;
  localparam int W1 = W + 1;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_state, w_next;
  logic [1:0] r_op;
  logic [W-1:0] r_b, r_quot, r_result;
  logic [2*W-1:0] r_prod;
  logic [W:0] r_rem;
  logic [CW-1:0] r_cnt;
  logic w_accept, w_dz, w_last, w_ge;
  logic [W:0] w_sum, w_rem_n;
  logic [W+1:0] w_sh;
  logic [2*W-1:0] w_prod_n;
  logic [W-1:0] w_quot_n, w_calc_res;
  always_comb begin
    w_accept = io_bus.i_start && r_state != CALC;
    w_dz = io_bus.i_op[1] && io_bus.i_op2 == '0;
    w_last = r_state == CALC && r_cnt == LAST;
    w_sum = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_b} : '0);
    w_prod_n = {w_sum, r_prod[W-1:1]};
    w_sh = {r_rem, r_quot[W-1]};
    w_ge = w_sh >= {2'b00, r_b};
    w_rem_n = w_ge ? W1'(w_sh - {2'b00, r_b}) : w_sh[W:0];
    w_quot_n = {r_quot[W-2:0], w_ge};
    w_calc_res = r_op == 2'b00 ? w_prod_n[W-1:0] :
                 r_op == 2'b01 ? w_prod_n[2*W-1:W] :
                 r_op == 2'b10 ? w_quot_n : w_rem_n[W-1:0];
    w_next = w_accept ? (w_dz ? DONE : CALC) : w_last ? DONE : r_state == CALC ? CALC : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op <= '0;
      r_b <= '0;
      r_prod <= '0;
      r_rem <= '0;
      r_quot <= '0;
      r_cnt <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op <= io_bus.i_op;
      r_b <= io_bus.i_op2;
      r_prod <= {{W{1'b0}}, io_bus.i_op1};
      r_rem <= '0;
      r_quot <= io_bus.i_op1;
      r_cnt <= '0;
      if (w_dz) r_result <= io_bus.i_op[0] ? io_bus.i_op1 : '1;
    end else if (r_state == CALC) begin
      r_prod <= w_prod_n;
      r_rem <= w_rem_n;
      r_quot <= w_quot_n;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_result <= w_calc_res;
    end
  end
  assign io_bus.o_busy = r_state == CALC;
  assign io_bus.o_done = r_state == DONE;
  assign io_bus.o_result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed vectors
module tb_muldiv_unit;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_acc = 0;
  int last_lat = 0;
  typedef struct {
    logic [W-1:0] res;
    int           at;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  muldiv_if #(.DATA_WIDTH(W)) bus();
  muldiv_unit #(.DATA_WIDTH(W)) dut (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  always @(negedge clk) begin
    chk("busy_and_done", W'(bus.o_busy && bus.o_done), '0);
    if (bus.o_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done with result %h, expected no done (cycle %0d)", bus.o_result, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("result", bus.o_result, mon_e.res);
        chk("done_cycle", W'(cyc), W'(mon_e.at));
      end
    end
  end
  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] res);
    last_lat = (op[1] && b == '0) ? 0 : W;
    bus.i_start = 1'b1;
    bus.i_op = op;
    bus.i_op1 = a;
    bus.i_op2 = b;
    @(posedge clk);
    #1;
    last_acc = cyc;
    sb.push_back('{res, cyc + last_lat});
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask
  task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] res);
    issue(op, a, b, res);
    wait_to(last_acc + last_lat + 1);
  endtask
  task automatic pulse(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.i_start = 1'b1;
    bus.i_op = op;
    bus.i_op1 = a;
    bus.i_op2 = b;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int a;
    int t;
    bus.i_start = 1'b0;
    bus.i_op = 2'b00;
    bus.i_op1 = '0;
    bus.i_op2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", W'(bus.o_busy), '0);
    chk("reset_done", W'(bus.o_done), '0);
    chk("reset_result", bus.o_result, '0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b00, 7, 6, 42);
    a = last_acc;
    chk("mul_busy_c1", W'(bus.o_busy), 1);
    wait_to(a + W - 1);
    chk("mul_busy_c32", W'(bus.o_busy), 1);
    chk("mul_done_c32", W'(bus.o_done), 0);
    wait_to(a + W);
    chk("mul_busy_c33", W'(bus.o_busy), 0);
    wait_to(a + W + 3);
    chk("mul_hold_42", bus.o_result, 42);
    chk("idle_busy", W'(bus.o_busy), 0);
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run(2'b10, 100, 7, 14);
    run(2'b11, 100, 7, 2);
    run(2'b10, 5, 9, 0);
    run(2'b11, 5, 9, 5);
    run(2'b10, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);
    run(2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF);
    issue(2'b10, 32'h1234, 0, 32'hFFFF_FFFF);
    chk("dz_divu_busy", W'(bus.o_busy), 0);
    issue(2'b11, 32'h1234, 0, 32'h1234);
    chk("dz_remu_busy", W'(bus.o_busy), 0);
    @(negedge clk);
    chk("dz_idle_busy", W'(bus.o_busy), 0);
    @(negedge clk);
    issue(2'b00, 7, 6, 42);
    a = last_acc;
    wait_to(a + 9);
    pulse(2'b00, 1, 1);
    wait_to(a + W);
    issue(2'b10, 100, 7, 14);
    chk("b2b_busy", W'(bus.o_busy), 1);
    chk("b2b_prev_result", bus.o_result, 42);
    wait_to(last_acc + W + 1);
    issue(2'b10, 100, 7, 14);
    a = last_acc;
    wait_to(a + 14);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", W'(bus.o_busy), 0);
    chk("abort_done", W'(bus.o_done), 0);
    chk("abort_result", bus.o_result, 0);
    rst_n = 1'b1;
    repeat (W + 5) @(negedge clk);
    run(2'b00, 3, 4, 12);
    t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide execution unit. It sits in the execute stage beside the single-cycle ALU and answers multi-cycle requests from the datapath/control with a start/busy/done handshake. It computes MUL (low word), MULHU (high word), DIVU and REMU, one bit per cycle. Operands come from the register-file read ports (rd1/rd2); the result goes to the same writeback mux as ALUout.

## Interface
- DATA_WIDTH, 32, operand/result width; must be ≥ 2; iteration count equals DATA_WIDTH.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request strobe; accepted only when state is IDLE or DONE.
- op  input  2  00 MUL, 01 MULHU, 10 DIVU, 11 REMU; captured with start.
- op1  input  DATA_WIDTH  multiplicand / dividend; captured with start.
- op2  input  DATA_WIDTH  multiplier / divisor; captured with start.
- busy  output  1  high while computing (state CALC).
- done  output  1  one-cycle pulse when result becomes valid.
- result  output  DATA_WIDTH  selected result; stable from done until the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE + start: capture op, op1, op2; clear iteration counter.
  - DIVU/REMU with op2 == 0: go to DONE directly.
  - Otherwise: go to CALC.
- CALC: one iteration per cycle; counter increments; after DATA_WIDTH iterations go to DONE.
- DONE: lasts exactly one cycle. With start, accept a new request exactly as from IDLE; otherwise go to IDLE.
- Multiply (shift-add):
  - 2*DATA_WIDTH-bit product register, initialised to {0, op1}.
  - Each iteration: if product LSB = 1, add op2 into the upper half with DATA_WIDTH+1-bit carry; then shift the whole register right by 1.
  - MUL = low half; MULHU = high half.
- Divide (restoring):
  - Remainder register is DATA_WIDTH+1 bits, initialised to 0; quotient register initialised to op1.
  - Each iteration: shift {rem, quot} left by 1; compute trial = rem − op2.
  - If trial is non-negative: rem = trial, quotient LSB = 1; else quotient LSB = 0.
  - DIVU = quotient; REMU = remainder low DATA_WIDTH bits.
- Divide by zero: DIVU returns all ones (0xFFFFFFFF at 32 bits); REMU returns op1. No trap.
- start while busy is ignored; captured operands and op are unaffected.
- Inputs are only sampled at acceptance; they may change freely during CALC.
- result is registered. It updates only on entry to DONE and holds through IDLE. During CALC it keeps the previous result.

## Timing
- Reset (rst_n low at a rising edge):
  - state = IDLE, busy = 0, done = 0, result = 0, counter = 0, internal datapath registers = 0.
  - Dominates start.
  - Reset during CALC aborts the operation; no done pulse follows.
- Normal request, start accepted at edge of cycle 0:
  - Cycles 1..DATA_WIDTH: busy = 1.
  - Cycle DATA_WIDTH+1: done = 1, busy = 0, result valid.
  - Latency = DATA_WIDTH+1 cycles (33 at 32 bits).
- Divide-by-zero request accepted at cycle 0: done = 1 and result valid in cycle 1; busy never asserts.
- Back-to-back: start held high in the DONE cycle begins the next request. busy rises the following cycle; result still shows the previous value until the next DONE.
- busy and done are never high together. done never stays high for two consecutive cycles except for back-to-back divide-by-zero requests.

## Test plan
- Reset, then MUL: op1 = 7, op2 = 6 -> busy cycles 1–32; done in cycle 33 with result = 42; result holds 42 in IDLE.
- MULHU: op1 = 0xFFFFFFFF, op2 = 0xFFFFFFFF -> result 0xFFFFFFFE. MUL on the same operands -> 0x00000001.
- DIVU then REMU: op1 = 100, op2 = 7 -> 14, then 2. Also op1 = 5, op2 = 9 -> DIVU 0, REMU 5.
- Divide by zero: DIVU 0x1234 / 0 -> done in cycle 1 with 0xFFFFFFFF. REMU 0x1234 / 0 -> 0x1234. busy stays 0.
- Start during busy: pulse start with op1 = 1, op2 = 1 at cycle 10 of a MUL 7×6 -> ignored; result 42 at cycle 33. Start held in the DONE cycle -> new operation begins; its done arrives 33 cycles later.
- Reset mid-operation: drive rst_n low at cycle 15 of DIVU -> next cycle busy = 0, done = 0, result = 0, and no done pulse. A following MUL 3×4 -> 12.
